// File: rtl/quad_odo_multi_if.sv
// rtl/quad_odo_multi_if.sv - host-side signal bundle for the quad_odo_multi odometer
//
// Groups the encoder pins, the control pulses and the published results so that
// the odometer core and its user connect through a single port.
//   code_a/code_b  encoder A/B pins per channel (asynchronous to clk)
//   clear          one-cycle pulse: zero all live position counters
//   err_clr        one-cycle pulse: clear all sticky quad_err bits
//   count          snapshot of all counters, channel i at [i*CNT_W +: CNT_W]
//   count_valid    one-cycle pulse marking a fresh snapshot
//   quad_err       sticky illegal-transition flag per channel
//   vel            (ODO_VELOCITY_EN only) counter change since the previous snapshot
// Modports: master = encoder/host side, slave = odometer core.
interface quad_odo_multi_if #(
  parameter int NCH   = 2,
  parameter int CNT_W = 32
);
  logic [NCH-1:0]       code_a;
  logic [NCH-1:0]       code_b;
  logic                 clear;
  logic                 err_clr;
  logic [NCH*CNT_W-1:0] count;
  logic                 count_valid;
  logic [NCH-1:0]       quad_err;
`ifdef ODO_VELOCITY_EN
  logic [NCH*CNT_W-1:0] vel;

  modport master (
    output code_a, code_b, clear, err_clr,
    input  count, count_valid, quad_err, vel
  );
  modport slave (
    input  code_a, code_b, clear, err_clr,
    output count, count_valid, quad_err, vel
  );
`else
  modport master (
    output code_a, code_b, clear, err_clr,
    input  count, count_valid, quad_err
  );
  modport slave (
    input  code_a, code_b, clear, err_clr,
    output count, count_valid, quad_err
  );
`endif
endinterface

// File: rtl/quad_odo_multi.sv
// rtl/quad_odo_multi.sv - multi-channel quadrature wheel odometer with periodic snapshot
//
// Each encoder pin is synchronised (2 flops) and deglitched (a new level is taken only
// after FILT_LEN consecutive differing samples). The filtered A/B pair is decoded x4
// (X4=1) or x1 (X4=0) into +1/-1 steps on a signed, wrapping per-channel counter.
// Both bits changing in one cycle is illegal: no step, sticky quad_err bit set.
// A shared timer copies all live counters into count every SAMPLE_DIV cycles and
// pulses count_valid alongside the new value.
// Optional feature macro ODO_VELOCITY_EN adds bus.vel = live counter minus the
// previous snapshot, published with count.
// Ports:
//   clk  system clock
//   rst  asynchronous active-low reset
//   bus  quad_odo_multi_if slave modport (pins, clear, err_clr, count, count_valid,
//        quad_err, and vel when enabled)
module quad_odo_multi #(
  parameter int NCH        = 2,
  parameter int CNT_W      = 32,
  parameter int FILT_LEN   = 3,
  parameter int SAMPLE_DIV = 100000,
  parameter int X4         = 1
) (
  input  logic             clk,
  input  logic             rst,
  quad_odo_multi_if.slave  bus
);

  // All A pins occupy [NCH-1:0] and all B pins [2*NCH-1:NCH] of the pin vectors.
  localparam int              NP         = 2 * NCH;
  localparam int              TW         = $clog2(SAMPLE_DIV);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [3:0]      FILT_LAST  = 4'(FILT_LEN - 1);

  logic [NP-1:0]        sync1_q, sync1_d;
  logic [NP-1:0]        sync2_q, sync2_d;
  logic [NP-1:0]        filt_q, filt_d;
  logic [NP-1:0]        prev_q, prev_d;
  logic [3:0]           fcnt_q [NP];
  logic [3:0]           fcnt_d [NP];
  logic [CNT_W-1:0]     pos_q [NCH];
  logic [CNT_W-1:0]     pos_d [NCH];
  logic [NCH-1:0]       err_q, err_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [NCH*CNT_W-1:0] count_q, count_d;
  logic                 count_valid_q, count_valid_d;
  logic [NCH-1:0]       step_up, step_dn, illegal;
  logic                 snap;
`ifdef ODO_VELOCITY_EN
  logic [CNT_W-1:0]     base_q [NCH];
  logic [CNT_W-1:0]     base_d [NCH];
  logic [NCH*CNT_W-1:0] vel_q, vel_d;
`endif

  // Position of an {A,B} state along the forward cycle 00->10->11->01.
  function automatic logic [1:0] phase_idx(input logic a, input logic b);
    return {b, a ^ b};
  endfunction

  // Synchroniser and per-pin persistence filter.
  always_comb begin
    sync1_d = {bus.code_b, bus.code_a};
    sync2_d = sync1_q;
    prev_d  = filt_q;
    filt_d  = filt_q;
    for (int j = 0; j < NP; j++) begin
      fcnt_d[j] = 4'd0;
      if (sync2_q[j] != filt_q[j]) begin
        if (fcnt_q[j] == FILT_LAST) begin
          filt_d[j] = sync2_q[j];
        end else begin
          fcnt_d[j] = fcnt_q[j] + 4'd1;
        end
      end
    end
  end

  // Decode: compare this cycle's filtered pair with last cycle's.
  always_comb begin
    step_up = '0;
    step_dn = '0;
    illegal = '0;
    for (int i = 0; i < NCH; i++) begin
      illegal[i] = (filt_q[i] ^ prev_q[i]) & (filt_q[NCH+i] ^ prev_q[NCH+i]);
      if (X4 != 0) begin
        // Index difference of 2 is the illegal double change and never steps.
        step_up[i] = (2'(phase_idx(filt_q[i], filt_q[NCH+i])
                       - phase_idx(prev_q[i], prev_q[NCH+i])) == 2'd1);
        step_dn[i] = (2'(phase_idx(filt_q[i], filt_q[NCH+i])
                       - phase_idx(prev_q[i], prev_q[NCH+i])) == 2'd3);
      end else begin
        if (filt_q[i] && !prev_q[i] && !illegal[i]) begin
          step_up[i] = !filt_q[NCH+i];
          step_dn[i] = filt_q[NCH+i];
        end
      end
    end
  end

  // Counters, error flags, snapshot timer.
  always_comb begin
    snap          = (timer_q == TIMER_LAST);
    timer_d       = snap ? '0 : timer_q + TW'(1);
    count_valid_d = snap;
    count_d       = count_q;
    // Set beats a same-cycle err_clr.
    err_d         = (err_q & ~{NCH{bus.err_clr}}) | illegal;
`ifdef ODO_VELOCITY_EN
    vel_d         = vel_q;
`endif
    for (int i = 0; i < NCH; i++) begin
      pos_d[i] = pos_q[i];
      if (bus.clear) begin
        pos_d[i] = '0;
      end else if (step_up[i]) begin
        pos_d[i] = pos_q[i] + CNT_W'(1);
      end else if (step_dn[i]) begin
        pos_d[i] = pos_q[i] - CNT_W'(1);
      end
      // The snapshot takes the counter value before this cycle's update.
      if (snap) begin
        count_d[i*CNT_W +: CNT_W] = pos_q[i];
      end
`ifdef ODO_VELOCITY_EN
      base_d[i] = base_q[i];
      if (snap) begin
        vel_d[i*CNT_W +: CNT_W] = pos_q[i] - base_q[i];
        base_d[i]               = pos_q[i];
      end
      if (bus.clear) begin
        base_d[i] = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      filt_q        <= '0;
      prev_q        <= '0;
      err_q         <= '0;
      timer_q       <= '0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
      for (int j = 0; j < NP; j++) fcnt_q[j] <= 4'd0;
      for (int i = 0; i < NCH; i++) pos_q[i] <= '0;
`ifdef ODO_VELOCITY_EN
      vel_q <= '0;
      for (int i = 0; i < NCH; i++) base_q[i] <= '0;
`endif
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      filt_q        <= filt_d;
      prev_q        <= prev_d;
      err_q         <= err_d;
      timer_q       <= timer_d;
      count_q       <= count_d;
      count_valid_q <= count_valid_d;
      for (int j = 0; j < NP; j++) fcnt_q[j] <= fcnt_d[j];
      for (int i = 0; i < NCH; i++) pos_q[i] <= pos_d[i];
`ifdef ODO_VELOCITY_EN
      vel_q <= vel_d;
      for (int i = 0; i < NCH; i++) base_q[i] <= base_d[i];
`endif
    end
  end

  assign bus.count       = count_q;
  assign bus.count_valid = count_valid_q;
  assign bus.quad_err    = err_q;
`ifdef ODO_VELOCITY_EN
  assign bus.vel         = vel_q;
`endif

endmodule

// File: tb/tb_quad_odo_multi.sv
// tb/tb_quad_odo_multi.sv - self-checking bench for quad_odo_multi
module tb_quad_odo_multi;
  localparam int NCH = 2;
  localparam int CW  = 32;
  localparam int FL  = 3;
  localparam int SD  = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  quad_odo_multi_if #(.NCH(NCH), .CNT_W(CW)) bus ();
  quad_odo_multi_if #(.NCH(NCH), .CNT_W(8))  b8 ();

  quad_odo_multi #(.NCH(NCH), .CNT_W(CW), .FILT_LEN(FL), .SAMPLE_DIV(SD), .X4(1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  quad_odo_multi #(.NCH(NCH), .CNT_W(8), .FILT_LEN(FL), .SAMPLE_DIV(SD), .X4(1)) dut8 (
    .clk(clk), .rst(rst), .bus(b8)
  );

  int total = 0;
  int bad   = 0;
  int pos [NCH];   // model: expected live position per channel
  int ph  [NCH];   // model: encoder phase 0..3 currently on the pins
  int p8, ph8;     // same for channel 0 of the 8-bit instance
`ifdef ODO_VELOCITY_EN
  logic [CW-1:0] vsum [NCH];
`endif

  function automatic logic [1:0] gray(input int p);
    case (p)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
`ifdef ODO_VELOCITY_EN
    if (bus.count_valid)
      for (int c = 0; c < NCH; c++) vsum[c] += bus.vel[c*CW +: CW];
`endif
  endtask

  task automatic drive(input int ch);
    logic [1:0] g;
    g = gray(ph[ch]);
    bus.code_a[ch] = g[1];
    bus.code_b[ch] = g[0];
  endtask

  task automatic step(input int ch, input int dir, input int hold);
    ph[ch]  = (ph[ch] + dir + 4) % 4;
    pos[ch] += dir;
    drive(ch);
    repeat (hold) tick();
  endtask

  task automatic wait_snap();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.count_valid && n < 40);
    total++;
    if (!bus.count_valid) begin
      bad++;
      $display("FAIL snap_timeout got=no count_valid want=count_valid within 40 clk");
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b0;
    repeat (3) tick();
    total++; if (bus.count !== '0) begin bad++; $display("FAIL reset_count got=%h want=0", bus.count); end
    total++; if (bus.count_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.count_valid); end
    total++; if (bus.quad_err !== 2'b00) begin bad++; $display("FAIL reset_err got=%b want=00", bus.quad_err); end
    rst = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!bus.count_valid && n < 30);
    total++; if (n != SD) begin bad++; $display("FAIL reset_first_valid got=%0d want=%0d", n, SD); end
  endtask

  task automatic test_forward();
    for (int s = 0; s < 8; s++) step(0, 1, 12);
    wait_snap();
    for (int c = 0; c < NCH; c++) begin
      total++;
      if (bus.count[c*CW +: CW] !== 32'(pos[c])) begin
        bad++; $display("FAIL fwd_count ch%0d got=%h want=%h", c, bus.count[c*CW +: CW], 32'(pos[c]));
      end
    end
    total++; if (bus.quad_err !== 2'b00) begin bad++; $display("FAIL fwd_err got=%b want=00", bus.quad_err); end
  endtask

  task automatic test_reverse();
    for (int s = 0; s < 3; s++) step(1, -1, 12);
    wait_snap();
    total++;
    if (bus.count[CW +: CW] !== 32'(pos[1])) begin
      bad++; $display("FAIL rev_count got=%h want=%h", bus.count[CW +: CW], 32'(pos[1]));
    end
  endtask

  task automatic test_glitch();
    int c, pin, len;
    bus.code_a[0] = ~bus.code_a[0];
    repeat (2) tick();
    drive(0);
    repeat (12) tick();
    for (int g = 0; g < 8; g++) begin
      c   = int'($urandom_range(0, NCH-1));
      pin = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, FL-1));
      if (pin == 0) bus.code_a[c] = ~bus.code_a[c];
      else          bus.code_b[c] = ~bus.code_b[c];
      repeat (len) tick();
      drive(c);
      repeat (3) tick();
    end
    repeat (8) tick();
    wait_snap();
    for (int k = 0; k < NCH; k++) begin
      total++;
      if (bus.count[k*CW +: CW] !== 32'(pos[k])) begin
        bad++; $display("FAIL glitch_count ch%0d got=%h want=%h", k, bus.count[k*CW +: CW], 32'(pos[k]));
      end
    end
    // A level held for FL+1 clocks is accepted and steps exactly once.
    step(0, 1, FL + 1);
    repeat (10) tick();
    wait_snap();
    total++;
    if (bus.count[0 +: CW] !== 32'(pos[0])) begin
      bad++; $display("FAIL held_step got=%h want=%h", bus.count[0 +: CW], 32'(pos[0]));
    end
  endtask

  task automatic test_illegal();
    ph[0] = (ph[0] + 2) % 4;
    drive(0);
    repeat (12) tick();
    wait_snap();
    total++; if (bus.quad_err !== 2'b01) begin bad++; $display("FAIL illegal_err got=%b want=01", bus.quad_err); end
    total++;
    if (bus.count[0 +: CW] !== 32'(pos[0])) begin
      bad++; $display("FAIL illegal_count got=%h want=%h", bus.count[0 +: CW], 32'(pos[0]));
    end
    bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0;
    total++; if (bus.quad_err !== 2'b00) begin bad++; $display("FAIL err_clr got=%b want=00", bus.quad_err); end
    // err_clr lands in the very cycle the illegal event registers: set wins.
    ph[0] = (ph[0] + 2) % 4;
    drive(0);
    repeat (2 + FL) tick();
    bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0;
    total++; if (bus.quad_err !== 2'b01) begin bad++; $display("FAIL err_set_wins got=%b want=01", bus.quad_err); end
    bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0;
    total++; if (bus.quad_err !== 2'b00) begin bad++; $display("FAIL err_clr2 got=%b want=00", bus.quad_err); end
  endtask

  task automatic test_clear();
    // Step on ch1 reaches the counter in the same cycle clear is high.
    ph[1] = (ph[1] + 1) % 4;
    drive(1);
    repeat (2 + FL) tick();
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
    for (int c = 0; c < NCH; c++) pos[c] = 0;
    repeat (10) tick();
    wait_snap();
    for (int c = 0; c < NCH; c++) begin
      total++;
      if (bus.count[c*CW +: CW] !== 32'(pos[c])) begin
        bad++; $display("FAIL clear_count ch%0d got=%h want=%h", c, bus.count[c*CW +: CW], 32'(pos[c]));
      end
    end
  endtask

  task automatic test_random();
    int h [NCH];
    int dir;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < NCH; c++) h[c] = 0;
      for (int cyc = 0; cyc < 60; cyc++) begin
        for (int c = 0; c < NCH; c++) begin
          if (h[c] == 0) begin
            dir     = int'($urandom_range(0, 2)) - 1;
            ph[c]   = (ph[c] + dir + 4) % 4;
            pos[c] += dir;
            drive(c);
            h[c]    = int'($urandom_range(FL + 1, 9));
          end
          h[c]--;
        end
        tick();
      end
      repeat (10) tick();
      wait_snap();
      for (int c = 0; c < NCH; c++) begin
        total++;
        if (bus.count[c*CW +: CW] !== 32'(pos[c])) begin
          bad++; $display("FAIL rand%0d_count ch%0d got=%h want=%h", r, c, bus.count[c*CW +: CW], 32'(pos[c]));
        end
      end
      total++; if (bus.quad_err !== 2'b00) begin bad++; $display("FAIL rand%0d_err got=%b want=00", r, bus.quad_err); end
    end
  endtask

  task automatic test_wrap8();
    logic [1:0] g;
    for (int s = 0; s < 128; s++) begin
      ph8 = (ph8 + 1) % 4;
      p8++;
      g = gray(ph8);
      b8.code_a[0] = g[1];
      b8.code_b[0] = g[0];
      repeat (5) tick();
      if (s == 126 || s == 127) begin
        repeat (8) tick();
        wait_snap();
        total++;
        if (b8.count[7:0] !== 8'(p8)) begin
          bad++; $display("FAIL wrap8_count step%0d got=%h want=%h", s + 1, b8.count[7:0], 8'(p8));
        end
      end
    end
    total++; if (b8.count[15:8] !== 8'h00) begin bad++; $display("FAIL wrap8_ch1 got=%h want=00", b8.count[15:8]); end
  endtask

`ifdef ODO_VELOCITY_EN
  task automatic test_velocity();
    repeat (10) tick();
    wait_snap();
    for (int c = 0; c < NCH; c++) vsum[c] = '0;
    for (int s = 0; s < 4; s++) step(0, 1, 5);
    repeat (10) tick();
    wait_snap();
    for (int c = 0; c < NCH; c++) begin
      total++;
      if (vsum[c] !== ((c == 0) ? 32'd4 : 32'd0)) begin
        bad++; $display("FAIL vel_sum ch%0d got=%h want=%h", c, vsum[c], (c == 0) ? 32'd4 : 32'd0);
      end
    end
    wait_snap();
    total++; if (bus.vel[0 +: CW] !== 32'd0) begin bad++; $display("FAIL vel_idle got=%h want=0", bus.vel[0 +: CW]); end
  endtask
`endif

  task automatic test_reset_mid();
    int n;
    while (ph[0] != 1) step(0, 1, 6);
    while (ph[1] != 0) step(1, 1, 6);
    repeat (8) tick();
    wait_snap();
    repeat (5) tick();
    rst = 1'b0;
    #1;
    total++; if (bus.count !== '0) begin bad++; $display("FAIL midrst_count got=%h want=0", bus.count); end
    total++; if (bus.count_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", bus.count_valid); end
    repeat (2) tick();
    // Filter restarts from 0: ch0 A held high gives one forward step after release.
    pos[0] = 1;
    pos[1] = 0;
    rst = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!bus.count_valid && n < 30);
    total++; if (n != SD) begin bad++; $display("FAIL midrst_first_valid got=%0d want=%0d", n, SD); end
    for (int c = 0; c < NCH; c++) begin
      total++;
      if (bus.count[c*CW +: CW] !== 32'(pos[c])) begin
        bad++; $display("FAIL midrst_count ch%0d got=%h want=%h", c, bus.count[c*CW +: CW], 32'(pos[c]));
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    rst         = 1'b0;
    bus.code_a  = '0; bus.code_b  = '0; bus.clear = 1'b0; bus.err_clr = 1'b0;
    b8.code_a   = '0; b8.code_b   = '0; b8.clear  = 1'b0; b8.err_clr  = 1'b0;
    for (int c = 0; c < NCH; c++) begin pos[c] = 0; ph[c] = 0; end
    p8  = 0;
    ph8 = 0;
`ifdef ODO_VELOCITY_EN
    for (int c = 0; c < NCH; c++) vsum[c] = '0;
`endif
    test_reset();
    test_forward();
    test_reverse();
    test_glitch();
    test_illegal();
    test_clear();
    test_random();
    test_wrap8();
`ifdef ODO_VELOCITY_EN
    test_velocity();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
